if_id_pipe: RTL

//  Parametrised IF/ID pipeline stage for the MIPS32 core. Accepts fetch PCs, drives a

---
 rtl/mips_pkg.sv | 15 +
 rtl/if_id_skid.sv | 108 ++++++++++
 rtl/if_id_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and state encodings for the MIPS32 front-end pipeline stages.
package mips_pkg;

    localparam logic [31:0] MIPS_NOP    = 32'h0000_0000;
    localparam int          PC_STEP_DEF = 4;
    localparam int          MEM_AW_DEF  = 10;

    // Entries owned by the IF/ID stage: OUT + SKID + in-flight fetch.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HALF  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/if_id_skid.sv
// Two-entry {pc, inst} FIFO (OUT register + SKID register) with the stage occupancy FSM
// that also counts the fetch still in flight in the instruction memory.
module if_id_skid
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              fetch_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic              pop_ready_i,
    output logic              ready_o,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [INST_W-1:0] out_inst_o
);

    occ_e              occ_q, occ_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic              skid_valid_q, skid_valid_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic              pop;

    assign pop = out_valid_q & pop_ready_i;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        occ_d        = occ_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        ready_o      = ~flush_i & ((occ_q != OCC_FULL) | (out_valid_q & pop_ready_i & ~skid_valid_q));

        if (flush_i) begin
            // Payload registers keep their last value so decode sees stable id_pc/id_inst.
            occ_d        = OCC_EMPTY;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            unique case ({fetch_i, pop})
                2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_HALF : OCC_FULL;
                2'b01:   occ_d = (occ_q == OCC_FULL) ? OCC_HALF : OCC_EMPTY;
                default: occ_d = occ_q;
            endcase

            if (pop) begin
                if (skid_valid_q) begin
                    out_pc_d     = skid_pc_q;
                    out_inst_d   = skid_inst_q;
                    skid_valid_d = 1'b0;
                end else if (push_i) begin
                    out_pc_d   = push_pc_i;
                    out_inst_d = push_inst_i;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (push_i) begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = push_pc_i;
                    out_inst_d  = push_inst_i;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = push_pc_i;
                    skid_inst_d  = push_inst_i;
                end
            end
        end
    end

    // NOTE: payload registers are reset too, because decode must see pc=0 / NOP out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q        <= OCC_EMPTY;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_inst_q   <= INST_W'(MIPS_NOP);
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_inst_q  <= INST_W'(MIPS_NOP);
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            occ_q        <= occ_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_pc_o    = out_pc_q;
    assign out_inst_o  = out_inst_q;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: drives a 1-cycle synchronous imem, pairs returning data with its PC
// and presents {pc+PC_STEP, inst} to decode. Optional stall counter under IF_ID_STALL_CNT_EN.
module if_id_pipe
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int MEM_AW  = MEM_AW_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_valid,
    output logic              if_ready,
    output logic [MEM_AW-1:0] imem_addr,
    output logic              imem_en,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic              if_fire;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              unused_pc_bits;

    assign if_fire   = if_valid & if_ready & ~flush;
    assign imem_en   = if_fire;
    assign imem_addr = if_pc[MEM_AW+1:2];

    assign unused_pc_bits = ^{if_pc[ADDR_W-1:MEM_AW+2], if_pc[1:0]};

    // Clearing the in-flight flag on flush is the kill: the rdata arriving next cycle is dropped.
    assign inflight_d = if_fire;
    assign tag_d      = if_fire ? if_pc : tag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    if_id_skid #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .fetch_i     (if_fire),
        .push_i      (inflight_q),
        .push_pc_i   (tag_q + ADDR_W'(PC_STEP)),
        .push_inst_i (imem_rdata),
        .pop_ready_i (id_ready),
        .ready_o     (if_ready),
        .out_valid_o (id_valid),
        .out_pc_o    (id_pc),
        .out_inst_o  (id_inst)
    );

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (id_valid && !id_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
